test_status_monitor: RTL and testbench

//  Synthesizable, parametrised successor to the single-core, fixed-tick riscv-tests startup bench.

---
 rtl/test_status_monitor.sv | 119 +++++++++++
 tb/tb_test_status_monitor.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/test_status_monitor.sv
// Per-channel riscv-tests tohost watcher: classifies each core as PASS, FAIL or TIMEOUT
// and flags aggregate done/pass for self-terminating sim and FPGA runs.
//
// state   | meaning
// IDLE    | not armed since reset
// RUN     | armed, waiting for a tohost write or timeout
// PASS    | tohost written with 1
// FAIL    | tohost written with odd value != 1, test number latched
// TIMEOUT | no verdict within TIMEOUT cycles of start
module test_status_monitor #(
   parameter int NCH = 1,
   parameter int AW = 32,
   parameter int DW = 32,
   parameter logic [AW-1:0] TOHOST_ADDR = 32'h0000_1000,
   parameter int TIMEOUT = 5000,
   parameter int CW = $clog2(TIMEOUT+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NCH-1:0]    wr_en,
   input  logic [NCH*AW-1:0] wr_addr,
   input  logic [NCH*DW-1:0] wr_data,
   output logic [NCH*3-1:0]  ch_state,
   output logic [NCH*DW-1:0] fail_test,
   output logic [CW-1:0]     cycles,
   output logic              done,
   output logic              pass
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b000,
      ST_RUN     = 3'b001,
      ST_PASS    = 3'b010,
      ST_FAIL    = 3'b011,
      ST_TIMEOUT = 3'b100
   } ch_st_e;

   ch_st_e        st_q [NCH];
   ch_st_e        st_d [NCH];
   logic [DW-1:0] ft_q [NCH];
   logic [DW-1:0] ft_d [NCH];
   logic [DW-1:0] wdat [NCH];
   logic [NCH-1:0] hit;
   logic [CW-1:0] cyc_d;
   logic          any_run;
   logic          tmo;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      assign wdat[g] = wr_data[g*DW +: DW];
      assign hit[g]  = wr_en[g] && (wr_addr[g*AW +: AW] == TOHOST_ADDR) && (st_q[g] == ST_RUN);
      assign ch_state[g*3 +: 3]   = st_q[g];
      assign fail_test[g*DW +: DW] = ft_q[g];
   end

   // Timeout fires on the TIMEOUT-th edge after start, i.e. while cycles still reads TIMEOUT-1.
   assign tmo = (cycles == CW'(TIMEOUT-1));

   always_comb begin
      any_run = 1'b0;
      for (int i = 0; i < NCH; i++)
         if (st_q[i] == ST_RUN) any_run = 1'b1;
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         st_d[i] = st_q[i];
         ft_d[i] = ft_q[i];
         if (start) begin
            st_d[i] = ST_RUN;
            ft_d[i] = '0;
         end else if (hit[i] && wdat[i][0]) begin
            if (wdat[i] == DW'(1)) begin
               st_d[i] = ST_PASS;
            end else begin
               st_d[i] = ST_FAIL;
               ft_d[i] = wdat[i] >> 1;
            end
         end else if (st_q[i] == ST_RUN && tmo) begin
            st_d[i] = ST_TIMEOUT;
         end
      end
   end

   always_comb begin
      cyc_d = cycles;
      if (start)
         cyc_d = '0;
      else if (any_run && cycles != '1)
         cyc_d = cycles + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NCH; i++) begin
            st_q[i] <= ST_IDLE;
            ft_q[i] <= '0;
         end
         cycles <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            st_q[i] <= st_d[i];
            ft_q[i] <= ft_d[i];
         end
         cycles <= cyc_d;
      end
   end

   always_comb begin
      done = 1'b1;
      pass = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         if (st_q[i] == ST_IDLE || st_q[i] == ST_RUN) done = 1'b0;
         if (st_q[i] != ST_PASS) pass = 1'b0;
      end
      pass = pass & done;
   end

endmodule

// File: tb/tb_test_status_monitor.sv
// Directed bench for test_status_monitor: a single-channel default instance and a
// two-channel instance with a short timeout.
module tb_test_status_monitor;

   localparam logic [31:0] TH = 32'h0000_1000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // single channel, TIMEOUT=5000
   logic        a_start = 1'b0;
   logic [0:0]  a_wr_en = '0;
   logic [31:0] a_addr = '0;
   logic [31:0] a_data = '0;
   logic [2:0]  a_state;
   logic [31:0] a_ft;
   logic [12:0] a_cyc;
   logic        a_done, a_pass;

   // two channels, TIMEOUT=16
   logic        b_start = 1'b0;
   logic [1:0]  b_wr_en = '0;
   logic [63:0] b_addr = '0;
   logic [63:0] b_data = '0;
   logic [5:0]  b_state;
   logic [63:0] b_ft;
   logic [4:0]  b_cyc;
   logic        b_done, b_pass;

   int n_checks = 0;
   int n_errors = 0;

   test_status_monitor u_dut_a (
      .clk(clk), .rst(rst), .start(a_start), .wr_en(a_wr_en), .wr_addr(a_addr),
      .wr_data(a_data), .ch_state(a_state), .fail_test(a_ft), .cycles(a_cyc),
      .done(a_done), .pass(a_pass));

   test_status_monitor #(.NCH(2), .TIMEOUT(16)) u_dut_b (
      .clk(clk), .rst(rst), .start(b_start), .wr_en(b_wr_en), .wr_addr(b_addr),
      .wr_data(b_data), .ch_state(b_state), .fail_test(b_ft), .cycles(b_cyc),
      .done(b_done), .pass(b_pass));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_write(input logic [31:0] addr, input logic [31:0] data);
      a_wr_en = 1'b1; a_addr = addr; a_data = data;
      step();
      a_wr_en = 1'b0;
   endtask

   initial begin
      #12;
      check("a_rst_state", a_state, 3'b000);
      check("a_rst_cyc",   a_cyc, 0);
      check("a_rst_done",  {a_done, a_pass}, 2'b00);
      check("b_rst_state", b_state, 6'b000_000);
      check("b_rst_ft",    b_ft, 64'h0);
      rst = 1'b1;
      step();

      // test 1: pass after 20 cycles
      a_start = 1'b1; step(); a_start = 1'b0;
      check("a_start_state", a_state, 3'b001);
      check("a_start_cyc",   a_cyc, 0);
      repeat (19) step();
      a_write(TH, 32'd1);
      check("a_pass_state", a_state, 3'b010);
      check("a_pass_cyc",   a_cyc, 20);
      check("a_pass_flags", {a_done, a_pass}, 2'b11);
      repeat (3) step();
      check("a_pass_hold_cyc", a_cyc, 20);
      a_write(TH, 32'd7);
      check("a_pass_sticky", a_state, 3'b010);

      // test 5 (a): ignored writes keep RUN; test 2: fail code
      a_start = 1'b1; step(); a_start = 1'b0;
      a_write(TH, 32'd0);
      a_write(TH, 32'd2);
      a_write(TH + 32'd4, 32'd1);
      check("a_ignored_state", a_state, 3'b001);
      check("a_ignored_done",  a_done, 1'b0);
      check("a_ignored_cyc",   a_cyc, 3);
      a_write(TH, 32'h0000_0007);
      check("a_fail_state", a_state, 3'b011);
      check("a_fail_test",  a_ft, 3);
      check("a_fail_flags", {a_done, a_pass}, 2'b10);

      // test 5 (b): writes before start do nothing
      b_wr_en = 2'b11; b_addr = {TH, TH}; b_data = {32'd1, 32'd1};
      step();
      b_wr_en = 2'b00;
      check("b_prestart_state", b_state, 6'b000_000);
      check("b_prestart_done",  b_done, 1'b0);

      // test 3: ch0 passes at cycle 5, ch1 times out on 16th edge
      b_start = 1'b1; step(); b_start = 1'b0;
      repeat (4) step();
      b_wr_en = 2'b01; b_addr = {32'h0, TH}; b_data = {32'h0, 32'd1};
      step();
      b_wr_en = 2'b00;
      check("b_ch0_pass", b_state, 6'b001_010);
      check("b_ch0_done", b_done, 1'b0);
      repeat (10) step();
      check("b_pre_tmo_state", b_state, 6'b001_010);
      check("b_pre_tmo_cyc",   b_cyc, 15);
      step();
      check("b_tmo_state", b_state, 6'b100_010);
      check("b_tmo_cyc",   b_cyc, 16);
      check("b_tmo_flags", {b_done, b_pass}, 2'b10);
      repeat (3) step();
      check("b_tmo_hold_cyc", b_cyc, 16);

      // test 4: hits on the timeout edge win
      b_start = 1'b1; step(); b_start = 1'b0;
      repeat (15) step();
      b_wr_en = 2'b11; b_addr = {TH, TH}; b_data = {32'd5, 32'd1};
      step();
      b_wr_en = 2'b00;
      check("b_edge_state", b_state, 6'b011_010);
      check("b_edge_ft",    b_ft, {32'd2, 32'd0});
      check("b_edge_flags", {b_done, b_pass}, 2'b10);

      // test 6: start overrides a same-cycle hit and clears results
      b_start = 1'b1;
      b_wr_en = 2'b01; b_addr = {32'h0, TH}; b_data = {32'h0, 32'd1};
      step();
      b_start = 1'b0; b_wr_en = 2'b00;
      check("b_restart_state", b_state, 6'b001_001);
      check("b_restart_ft",    b_ft, 64'h0);
      check("b_restart_cyc",   b_cyc, 0);
      repeat (4) step();
      check("b_run_cyc", b_cyc, 4);

      // async reset mid-cycle, no clock edge in between
      #2;
      rst = 1'b0;
      #1;
      check("b_async_state", b_state, 6'b000_000);
      check("b_async_cyc",   b_cyc, 0);
      check("a_async_state", a_state, 3'b000);
      check("b_async_done",  b_done, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
